fwd_scoreboard: RTL

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard_pkg.sv | 21 ++
 rtl/fwd_scoreboard_port_sel.sv | 57 +++++
 rtl/fwd_scoreboard.sv | 107 ++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and defaults for the operand forwarding scoreboard.
package pipes;

  // Default parameter values for the scoreboard.
  localparam int NREAD_DEF  = 2;
  localparam int NSTAGE_DEF = 3;
  localparam int LAT_W_DEF  = 4;

  // Architectural register index; register 0 is hard-wired zero.
  localparam int CREG_W = 5;
  typedef logic [CREG_W-1:0] creg_addr_t;

  // Operand source select: 0 = regfile, k = stage k-1, NSTAGE+1 = multi-cycle unit.
  // Three bits cover up to six producer stages.
  localparam int FWD_SEL_W = 3;
  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REGFILE = fwd_sel_t'(0);
  localparam fwd_sel_t FWD_MC      = fwd_sel_t'(NSTAGE_DEF + 1);

endpackage : pipes

// File: rtl/fwd_scoreboard_port_sel.sv
// Per-read-port forwarding priority select and data-hazard detection.
module fwd_port_sel
  import pipes::*;
#(
  parameter int       NSTAGE = NSTAGE_DEF,
  parameter fwd_sel_t SEL_MC = FWD_MC
) (
  input  creg_addr_t        ra,
  input  logic              ra_valid,
  input  logic [NSTAGE-1:0] st_valid,
  input  logic [NSTAGE-1:0] st_wen,
  input  creg_addr_t        st_dst [NSTAGE],
  input  logic [NSTAGE-1:0] st_ready,
  input  logic              mc_done,
  input  logic              mc_busy,
  input  creg_addr_t        mc_dst,
  output fwd_sel_t          sel,
  output logic              stall
);

  logic     hit;
  logic     hit_ready;
  fwd_sel_t hit_sel;

  // Youngest matching stage wins: scan oldest to youngest so later writes override.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default up front,
    // otherwise paths that skip an assignment infer a latch.
    hit       = 1'b0;
    hit_ready = 1'b0;
    hit_sel   = FWD_REGFILE;
    for (int s = NSTAGE - 1; s >= 0; s--) begin
      if (st_valid[s] && st_wen[s] && (st_dst[s] != '0) && (st_dst[s] == ra)) begin
        hit       = 1'b1;
        hit_ready = st_ready[s];
        hit_sel   = fwd_sel_t'(s + 1);
      end
    end
  end

  // Resolve the operand source; pipeline stages take precedence over the multi-cycle unit.
  always_comb begin
    sel   = FWD_REGFILE;
    stall = 1'b0;
    if (ra_valid && (ra != '0)) begin
      if (hit) begin
        sel   = hit_sel;
        stall = !hit_ready;
      end else if (mc_done && (mc_dst == ra)) begin
        sel = SEL_MC;
      end else if (mc_busy && (mc_dst == ra)) begin
        stall = 1'b1;
      end
    end
  end

endmodule : fwd_port_sel

// File: rtl/fwd_scoreboard.sv
// Operand forwarding scoreboard: per-port bypass select, issue stall,
// and tracking of a single outstanding multi-cycle (mul/div) operation.
module fwd_scoreboard
  import pipes::*;
#(
  parameter int NREAD  = NREAD_DEF,
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int LAT_W  = LAT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  creg_addr_t        ra       [NREAD],
  input  logic [NREAD-1:0]  ra_valid,
  input  logic [NSTAGE-1:0] st_valid,
  input  logic [NSTAGE-1:0] st_wen,
  input  creg_addr_t        st_dst   [NSTAGE],
  input  logic [NSTAGE-1:0] st_ready,
  input  logic              mc_issue,
  input  creg_addr_t        mc_dst,
  input  logic [LAT_W-1:0]  mc_lat,
  input  logic              flush,
  output fwd_sel_t          fwd_sel  [NREAD],
  output logic              stall,
  output logic              mc_busy,
  output logic              mc_done,
  output creg_addr_t        mc_wdst,
  output logic [31:0]       stall_cnt
);

  localparam fwd_sel_t SEL_MC = fwd_sel_t'(NSTAGE + 1);

  logic             busy_q, busy_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  creg_addr_t       dst_q, dst_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic [NREAD-1:0] port_stall;
  logic             struct_hz;
  logic             issue_ok;

  assign mc_busy   = busy_q;
  assign mc_wdst   = dst_q;
  assign stall_cnt = stall_cnt_q;

  // Result completes while the counter sits at 1; a flush in that cycle kills it.
  assign mc_done   = busy_q && (cnt_q == LAT_W'(1)) && !flush;
  assign struct_hz = mc_issue && busy_q && !mc_done;
  assign stall     = (|port_stall) || struct_hz;
  // Back-to-back issue is allowed in the completion cycle.
  assign issue_ok  = mc_issue && (!busy_q || mc_done) && !stall && !flush;

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    fwd_port_sel #(
      .NSTAGE (NSTAGE),
      .SEL_MC (SEL_MC)
    ) u_sel (
      .ra       (ra[p]),
      .ra_valid (ra_valid[p]),
      .st_valid (st_valid),
      .st_wen   (st_wen),
      .st_dst   (st_dst),
      .st_ready (st_ready),
      .mc_done  (mc_done),
      .mc_busy  (busy_q),
      .mc_dst   (dst_q),
      .sel      (fwd_sel[p]),
      .stall    (port_stall[p])
    );
  end

  // Next-state for the multi-cycle tracker and the stall counter.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    dst_d  = dst_q;
    if (flush) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (issue_ok) begin
      busy_d = 1'b1;
      cnt_d  = (mc_lat == '0) ? LAT_W'(1) : mc_lat;
      dst_d  = mc_dst;
    end else if (busy_q) begin
      cnt_d = cnt_q - LAT_W'(1);
      if (cnt_q == LAT_W'(1)) busy_d = 1'b0;
    end
    stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  // State registers, cleared asynchronously so reset abandons any in-flight op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      dst_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples
      // pre-edge values regardless of statement order.
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      dst_q       <= dst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule : fwd_scoreboard
